// File: rtl/seq_tx_pkg.sv
// -----------------------------------------------------------------------------
// seq_tx_pkg
// Shared types and helpers for the serial bit-stream transmitter.
//   - tx_state_e  : transmitter FSM states (PAR is used only when the
//                   SEQ_TX_PARITY_EN macro is defined)
//   - DEF_WIDTH   : default word width
//   - DEF_CNT_W   : default repeat-count field width
//   - even_parity : XOR reduction of a (zero-extended) word
// -----------------------------------------------------------------------------
package seq_tx_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      PAR   = 2'd2
   } tx_state_e;

   localparam int DEF_WIDTH = 8;
   localparam int DEF_CNT_W = 4;

   // Even-parity bit: words up to 64 bits, zero-extended by the caller.
   function automatic logic even_parity(input logic [63:0] v);
      return ^v;
   endfunction

endpackage

// File: rtl/seq_tx_shreg.sv
// -----------------------------------------------------------------------------
// seq_tx_shreg
// WIDTH-bit load / shift-left register. Load has priority over shift.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   load      : capture din on the next edge
//   shift     : shift left by one on the next edge (zero fill)
//   din       : parallel load value
//   msb_next  : MSB of the value the register takes on the next edge; the
//               parent registers this into its serial output so that the bit
//               and the register advance on the same edge
// -----------------------------------------------------------------------------
module seq_tx_shreg #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic             shift,
   input  logic [WIDTH-1:0] din,
   output logic             msb_next
);

   logic [WIDTH-1:0] data_q;
   logic [WIDTH-1:0] data_d;

   // Next register contents: load, shift left, or hold.
   always_comb begin
      data_d = data_q;
      if (load) begin
         data_d = din;
      end else if (shift) begin
         data_d = {data_q[WIDTH-2:0], 1'b0};
      end else begin
         data_d = data_q;
      end
      msb_next = data_d[WIDTH-1];
   end

   // Shift register storage.
   always_ff @(posedge clk) begin
      if (rst) begin
         data_q <= {WIDTH{1'b0}};
      end else begin
         data_q <= data_d;
      end
   end

endmodule

// File: rtl/seq_bit_tx.sv
// -----------------------------------------------------------------------------
// seq_bit_tx
// Serial bit-stream transmitter: accepts a WIDTH-bit word over valid/ready and
// shifts it out MSB-first, one bit per clock, repeating the frame
// load_reps+1 times back-to-back.
// Optional feature macro: SEQ_TX_PARITY_EN -- appends an even-parity bit
// (PAR state) to every frame; w_last then marks the parity bit.
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   load_valid  : word offered
//   load_ready  : transmitter idle and not in reset (combinational)
//   load_data   : word to transmit, MSB first
//   load_reps   : extra repetitions of the frame
//   w, w_valid  : registered serial bit and its qualifier (w is 0 when idle)
//   w_last      : registered, final bit of the current frame
//   busy        : registered, a frame sequence is in progress
//   done        : registered, one-cycle pulse in the first idle cycle
// -----------------------------------------------------------------------------
module seq_bit_tx
   import seq_tx_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int CNT_W = DEF_CNT_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load_valid,
   output logic             load_ready,
   input  logic [WIDTH-1:0] load_data,
   input  logic [CNT_W-1:0] load_reps,
   output logic             w,
   output logic             w_valid,
   output logic             w_last,
   output logic             busy,
   output logic             done
);

   localparam int BCW = $clog2(WIDTH);
   localparam logic [BCW-1:0] LAST_IDX     = BCW'(WIDTH - 1);
   localparam logic [BCW-1:0] PRE_LAST_IDX = BCW'(WIDTH - 2);
`ifdef SEQ_TX_PARITY_EN
   localparam logic PAR_EN = 1'b1;
`else
   localparam logic PAR_EN = 1'b0;
`endif

   tx_state_e        state_q, state_d;
   logic [BCW-1:0]   bit_cnt_q, bit_cnt_d;
   logic [CNT_W-1:0] rep_cnt_q, rep_cnt_d;
   logic [WIDTH-1:0] word_q, word_d;
   logic             w_q, w_d;
   logic             w_valid_q, w_valid_d;
   logic             w_last_q, w_last_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   logic             frame_end_s;
   logic             sh_load_s;
   logic             sh_shift_s;
   logic [WIDTH-1:0] sh_din_s;
   logic             sh_msb_next_s;

   seq_tx_shreg #(.WIDTH(WIDTH)) u_shreg (
      .clk      (clk),
      .rst      (rst),
      .load     (sh_load_s),
      .shift    (sh_shift_s),
      .din      (sh_din_s),
      .msb_next (sh_msb_next_s)
   );

   // FSM next state, counters, shift-register control and output qualifiers.
   // bit_cnt_q is the index of the bit currently presented on w.
   always_comb begin
      state_d     = state_q;
      bit_cnt_d   = bit_cnt_q;
      rep_cnt_d   = rep_cnt_q;
      word_d      = word_q;
      w_valid_d   = 1'b0;
      w_last_d    = 1'b0;
      done_d      = 1'b0;
      frame_end_s = 1'b0;
      sh_load_s   = 1'b0;
      sh_shift_s  = 1'b0;
      sh_din_s    = word_q;

      case (state_q)
         IDLE: begin
            if (load_valid) begin
               state_d   = SHIFT;
               word_d    = load_data;
               rep_cnt_d = load_reps;
               bit_cnt_d = {BCW{1'b0}};
               sh_load_s = 1'b1;
               sh_din_s  = load_data;
               w_valid_d = 1'b1;
            end else begin
               state_d = IDLE;
            end
         end
         SHIFT: begin
            if (bit_cnt_q != LAST_IDX) begin
               sh_shift_s = 1'b1;
               bit_cnt_d  = bit_cnt_q + BCW'(1'b1);
               w_valid_d  = 1'b1;
               w_last_d   = (bit_cnt_q == PRE_LAST_IDX) && !PAR_EN;
            end else begin
`ifdef SEQ_TX_PARITY_EN
               state_d   = PAR;
               w_valid_d = 1'b1;
               w_last_d  = 1'b1;
`else
               frame_end_s = 1'b1;
`endif
            end
         end
`ifdef SEQ_TX_PARITY_EN
         PAR: begin
            frame_end_s = 1'b1;
         end
`endif
         default: begin
            state_d = IDLE;
         end
      endcase

      // End of frame: restart from the latched word with no gap, or finish.
      if (frame_end_s) begin
         if (rep_cnt_q != {CNT_W{1'b0}}) begin
            rep_cnt_d = rep_cnt_q - CNT_W'(1'b1);
            bit_cnt_d = {BCW{1'b0}};
            sh_load_s = 1'b1;
            sh_din_s  = word_q;
            state_d   = SHIFT;
            w_valid_d = 1'b1;
         end else begin
            state_d = IDLE;
            done_d  = 1'b1;
         end
      end else begin
         done_d = 1'b0;
      end

      busy_d = (state_d != IDLE);
   end

   // Serial data bit for the next cycle; separate block so the path through
   // the shift register's msb_next stays acyclic.
   always_comb begin
      w_d = 1'b0;
      case (state_d)
         SHIFT: begin
            w_d = sh_msb_next_s;
         end
`ifdef SEQ_TX_PARITY_EN
         PAR: begin
            w_d = even_parity(64'(word_q));
         end
`endif
         default: begin
            w_d = 1'b0;
         end
      endcase
   end

   // State, counters and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         bit_cnt_q <= {BCW{1'b0}};
         rep_cnt_q <= {CNT_W{1'b0}};
         word_q    <= {WIDTH{1'b0}};
         w_q       <= 1'b0;
         w_valid_q <= 1'b0;
         w_last_q  <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         bit_cnt_q <= bit_cnt_d;
         rep_cnt_q <= rep_cnt_d;
         word_q    <= word_d;
         w_q       <= w_d;
         w_valid_q <= w_valid_d;
         w_last_q  <= w_last_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
      end
   end

   assign load_ready = (state_q == IDLE) && !rst;
   assign w          = w_q;
   assign w_valid    = w_valid_q;
   assign w_last     = w_last_q;
   assign busy       = busy_q;
   assign done       = done_q;

endmodule

// File: tb/tb_seq_bit_tx.sv
// -----------------------------------------------------------------------------
// tb_seq_bit_tx
// Directed bench for seq_bit_tx (WIDTH=8, CNT_W=4). Each cycle the observed
// vector {w, w_valid, w_last, busy, done, load_ready} is compared with a
// hand-derived expectation. Parity cases run when SEQ_TX_PARITY_EN is defined.
// -----------------------------------------------------------------------------
module tb_seq_bit_tx;

   localparam int WIDTH = 8;
   localparam int CNT_W = 4;
`ifdef SEQ_TX_PARITY_EN
   localparam int FL = 9;
`else
   localparam int FL = 8;
`endif

   logic             clk = 1'b0;
   logic             rst;
   logic             load_valid;
   logic             load_ready;
   logic [WIDTH-1:0] load_data;
   logic [CNT_W-1:0] load_reps;
   logic             w;
   logic             w_valid;
   logic             w_last;
   logic             busy;
   logic             done;

   int n_cmp = 0;
   int n_bad = 0;

   seq_bit_tx #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
      .clk        (clk),
      .rst        (rst),
      .load_valid (load_valid),
      .load_ready (load_ready),
      .load_data  (load_data),
      .load_reps  (load_reps),
      .w          (w),
      .w_valid    (w_valid),
      .w_last     (w_last),
      .busy       (busy),
      .done       (done)
   );

   always #5 clk = ~clk;

   // Expected serial bit at position p of a frame (p==8 is the parity bit).
   function automatic logic exp_bit(input logic [7:0] d, input int p);
      if (p < 8) return d[7-p];
      return ^d;
   endfunction

   // Offer a word at a negedge; the following posedge is the accept edge.
   task automatic send(input logic [7:0] d, input logic [3:0] r);
      @(negedge clk);
      load_valid = 1'b1;
      load_data  = d;
      load_reps  = r;
      @(posedge clk);
      #1 load_valid = 1'b0;
   endtask

   task automatic test_reset();
      logic [5:0] obs;
      rst        = 1'b1;
      load_valid = 1'b1;
      load_data  = 8'hAA;
      load_reps  = 4'd0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      obs = {w, w_valid, w_last, busy, done, load_ready};
      n_cmp++;
      if (obs !== 6'b000000) begin
         n_bad++;
         $display("FAIL reset_hold got %b exp %b", obs, 6'b000000);
      end
      rst        = 1'b0;
      load_valid = 1'b0;
      @(negedge clk);
      obs = {w, w_valid, w_last, busy, done, load_ready};
      n_cmp++;
      if (obs !== 6'b000001) begin
         n_bad++;
         $display("FAIL reset_release got %b exp %b", obs, 6'b000001);
      end
   endtask

   task automatic test_single(input logic [7:0] d);
      logic [5:0] obs;
      logic [5:0] exp;
      send(d, 4'd0);
      for (int k = 1; k <= FL + 2; k++) begin
         @(negedge clk);
         if (k <= FL) exp = {exp_bit(d, k - 1), 1'b1, (k == FL), 1'b1, 1'b0, 1'b0};
         else if (k == FL + 1) exp = 6'b000011;
         else exp = 6'b000001;
         obs = {w, w_valid, w_last, busy, done, load_ready};
         n_cmp++;
         if (obs !== exp) begin
            n_bad++;
            $display("FAIL single d=%h cycle=%0d got %b exp %b", d, k, obs, exp);
         end
      end
   endtask

   task automatic test_repeat();
      logic [5:0] obs;
      logic [5:0] exp;
      send(8'h81, 4'd2);
      for (int k = 1; k <= 3 * FL + 2; k++) begin
         @(negedge clk);
         if (k <= 3 * FL) exp = {exp_bit(8'h81, (k - 1) % FL), 1'b1, (k % FL == 0), 1'b1, 1'b0, 1'b0};
         else if (k == 3 * FL + 1) exp = 6'b000011;
         else exp = 6'b000001;
         obs = {w, w_valid, w_last, busy, done, load_ready};
         n_cmp++;
         if (obs !== exp) begin
            n_bad++;
            $display("FAIL repeat cycle=%0d got %b exp %b", k, obs, exp);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [5:0] obs;
      logic [5:0] exp;
      send(8'h3C, 4'd0);
      // A competing word is held valid throughout the frame; it must be ignored.
      load_valid = 1'b1;
      load_data  = 8'hFF;
      load_reps  = 4'd5;
      for (int k = 1; k <= FL + 1; k++) begin
         @(negedge clk);
         if (k <= FL) exp = {exp_bit(8'h3C, k - 1), 1'b1, (k == FL), 1'b1, 1'b0, 1'b0};
         else exp = 6'b000011;
         obs = {w, w_valid, w_last, busy, done, load_ready};
         n_cmp++;
         if (obs !== exp) begin
            n_bad++;
            $display("FAIL hold_ignore cycle=%0d got %b exp %b", k, obs, exp);
         end
      end
      // Accept a new word on the done cycle.
      load_data = 8'hC3;
      load_reps = 4'd0;
      @(posedge clk);
      #1 load_valid = 1'b0;
      for (int k = 1; k <= FL + 1; k++) begin
         @(negedge clk);
         if (k <= FL) exp = {exp_bit(8'hC3, k - 1), 1'b1, (k == FL), 1'b1, 1'b0, 1'b0};
         else exp = 6'b000011;
         obs = {w, w_valid, w_last, busy, done, load_ready};
         n_cmp++;
         if (obs !== exp) begin
            n_bad++;
            $display("FAIL accept_on_done cycle=%0d got %b exp %b", k, obs, exp);
         end
      end
   endtask

   task automatic test_abort();
      logic [5:0] obs;
      logic [5:0] exp;
      send(8'hF0, 4'd3);
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk);
         exp = {exp_bit(8'hF0, k - 1), 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
         obs = {w, w_valid, w_last, busy, done, load_ready};
         n_cmp++;
         if (obs !== exp) begin
            n_bad++;
            $display("FAIL abort_pre cycle=%0d got %b exp %b", k, obs, exp);
         end
      end
      rst = 1'b1;
      @(negedge clk);
      obs = {w, w_valid, w_last, busy, done, load_ready};
      n_cmp++;
      if (obs !== 6'b000000) begin
         n_bad++;
         $display("FAIL abort_reset got %b exp %b", obs, 6'b000000);
      end
      rst = 1'b0;
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);
         obs = {w, w_valid, w_last, busy, done, load_ready};
         n_cmp++;
         if (obs !== 6'b000001) begin
            n_bad++;
            $display("FAIL abort_quiet cycle=%0d got %b exp %b", k, obs, 6'b000001);
         end
      end
   endtask

`ifdef SEQ_TX_PARITY_EN
   task automatic test_parity();
      // 8'h07 has three ones: parity bit 1, marked with w_last.
      test_single(8'h07);
      n_cmp++;
      if (exp_bit(8'h07, 8) !== 1'b1) begin
         n_bad++;
         $display("FAIL parity_model got %b exp %b", exp_bit(8'h07, 8), 1'b1);
      end
   endtask
`endif

   initial begin
      rst        = 1'b1;
      load_valid = 1'b0;
      load_data  = 8'h00;
      load_reps  = 4'd0;
      test_reset();
      test_single(8'hB4);
      test_repeat();
      test_back_to_back();
      test_abort();
`ifdef SEQ_TX_PARITY_EN
      test_parity();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/seq_bit_tx.md
# seq_bit_tx

Serial bit-stream transmitter that turns parallel words into the one-bit-per-clock `w` stream consumed by the group's sequence-detector FSMs. It accepts a WIDTH-bit word through a valid/ready handshake and shifts it out MSB-first. It can repeat the word back-to-back a programmable number of times. It is the driving end of the detector's `w` input: it drives the detector bench stimulus and on-chip pattern injection.

## Interface
Parameters:
- `WIDTH`, 8: bits per word (≥2).
- `CNT_W`, 4: width of the repeat-count field.

Ports:
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst`  in  1  synchronous reset, active-high.
- `load_valid`  in  1  word offered.
- `load_ready`  out  1  transmitter can accept a word.
- `load_data`  in  WIDTH  word to transmit, MSB first.
- `load_reps`  in  CNT_W  extra repetitions; the frame is sent `load_reps+1` times.
- `w`  out  1  serial data bit; registered.
- `w_valid`  out  1  `w` carries a frame bit this cycle; registered.
- `w_last`  out  1  final bit of the current frame; registered.
- `busy`  out  1  frame transmission in progress.
- `done`  out  1  one-cycle pulse after the final frame completes.

## Operation
- State machine states:
  - `IDLE`: `load_ready=1`.
  - `SHIFT`: emitting data bits.
  - `PAR`: emitting the parity bit; present only with the macro in the Configuration section.
- Accept:
  - A word is taken when `load_valid && load_ready` at a rising edge.
  - On accept, latch `load_data` into the shift register, `load_reps` into the repeat counter, and zero the bit counter.
  - `load_valid` outside `IDLE` is ignored; no queueing.
- `SHIFT`:
  - Drive the shift register MSB on `w`, with `w_valid=1`; shift left by one each cycle.
  - On bit index WIDTH-1, assert `w_last=1` unless `PAR` follows.
- End of frame:
  - If the repeat counter is nonzero, decrement it, reload the shift register from the latched word, and start the next frame in the very next cycle. There is no gap between frames.
  - If the repeat counter is zero, go to `IDLE` and pulse `done`.
- `busy` = state ≠ `IDLE`.
- `load_ready` = (state == `IDLE`) && !`rst`.
- `done` and `load_ready` are both high in the first `IDLE` cycle, so a new word may be accepted that cycle.
- When `w_valid=0`, `w` is held at 0.
- Reset values: `w=0`, `w_valid=0`, `w_last=0`, `busy=0`, `done=0`; `load_ready=0` while `rst=1`; state `IDLE`; counters 0.
- Reset mid-frame: aborts on the next edge. Outputs take their reset values and no `done` is issued.
- Repeat counter arithmetic: CNT_W-bit unsigned with no wrap. The maximum count is 2^CNT_W frames.

## Timing
- Latency: the first bit appears on `w` in the cycle after the accept edge.
- One frame lasts WIDTH cycles, or WIDTH+1 with parity.
- Total `w_valid` cycles = (`load_reps`+1) × frame length.
- `done` asserts in the cycle after the final `w_last`, for exactly one cycle.
- Minimum spacing between words: one `IDLE` cycle. Accept on the `done` cycle; the next first bit follows one cycle later.
- All outputs are registered except `load_ready`, which is decoded from state and `rst`.

## Configuration
- Macro `SEQ_TX_PARITY_EN`.
- Defined:
  - After each frame's WIDTH data bits, one `PAR` cycle emits the even-parity bit (XOR of the latched word), with `w_valid=1` and `w_last=1`.
  - The repeat decision is taken after `PAR`.
- Undefined:
  - The `PAR` state and parity logic are absent.
  - `w_last` falls on data bit WIDTH-1.

## Structure
- Package `seq_tx_pkg` contains:
  - the state enum (`IDLE`, `SHIFT`, `PAR`);
  - the `DEF_WIDTH` and `DEF_CNT_W` constants;
  - an even-parity function.
- One sub-module, `seq_tx_shreg`: a WIDTH-bit load/shift-left register with MSB output.
- The FSM, bit counter and repeat counter live in `seq_bit_tx`.

## Test plan
All scenarios use WIDTH=8.
- Reset: hold `rst=1` for 2 cycles, with `load_valid=1` during reset → `w=0`, `w_valid=0`, `busy=0`, `done=0`, `load_ready=0`; `load_ready=1` the cycle after release.
- Single frame: `8'hB4`, reps=0 → `w` = 1,0,1,1,0,1,0,0 in cycles 1–8 after accept; `w_last` in cycle 8; `done` in cycle 9.
- Repeat: `8'h81`, reps=2 → 24 contiguous `w_valid` cycles; `w_last` in cycles 8, 16, 24; `done` in cycle 25.
- Handshake under load:
  - Hold `load_valid=1` with `8'hFF` during a frame → ignored, and `load_ready=0` throughout the frame.
  - Accept on the `done` cycle → that word's first bit follows one cycle later.
- Abort: assert `rst` at bit 4 of a frame → next cycle all outputs at reset values; no `done` ever follows.
- Parity with `SEQ_TX_PARITY_EN`:
  - `8'hB4` → 9th bit 0 with `w_last`; `done` in cycle 10.
  - `8'h07` → 9th bit 1.
